// File: rtl/mms_stream_ctrl.sv
// mms_stream_ctrl
//   Sequencing controller for a serial min/max-select (MMS) reduction.
//   Accepts DW-bit unsigned samples one per cycle over valid/ready. It folds
//   each frame of N samples into a single min or max using one shared
//   comparator, then presents the result on a valid/ready output port.
//
// Parameters
//   DW  sample/result width (unsigned)
//   N   samples per frame, N >= 1
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears all state
//   clear       synchronous frame abort (below reset in priority)
//   in_valid    in_data/in_sel valid
//   in_ready    a sample is accepted this cycle when in_valid is also high
//   in_data     sample
//   in_sel      1 = min, 0 = max; taken from the first sample of a frame only
//   out_valid   out_result holds a completed frame result
//   out_ready   downstream accepts the result
//   out_result  frame min/max
//   out_sel     select value that produced out_result
//   busy        controller is not idle
module mms_stream_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_sel,
  output logic          busy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic in_lt;
  logic take;

  always_comb begin
    // in_ready depends only on registered state and out_ready/clear/reset.
    in_ready = !reset && !clear && ((state_q != DONE) || out_ready);
    accept   = in_valid && in_ready;

    // Single comparator: "take" selects the incoming sample. For max, an
    // equal sample is taken, which leaves the same value in acc.
    in_lt = (in_data < acc_q);
    take  = sel_q ? in_lt : !in_lt;

    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = in_data;
            sel_d   = in_sel;
            cnt_d   = CNT_ONE;
            state_d = (N > 1) ? ACC : DONE;
          end
        end
        ACC: begin
          if (accept) begin
            if (take) acc_d = in_data;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              // Result handed off and the next frame's first sample loaded
              // in the same cycle.
              acc_d   = in_data;
              sel_d   = in_sel;
              cnt_d   = CNT_ONE;
              state_d = (N > 1) ? ACC : DONE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_result = acc_q;
  assign out_sel    = sel_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mms_stream_ctrl.sv
// Directed testbench for mms_stream_ctrl: an N=8 instance plus an N=1 instance.
module tb_mms_stream_ctrl;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_sel;
  logic       busy;

  logic       u1_in_valid;
  logic       u1_in_ready;
  logic [7:0] u1_in_data;
  logic       u1_in_sel;
  logic       u1_out_valid;
  logic       u1_out_ready;
  logic [7:0] u1_out_result;
  logic       u1_out_sel;
  logic       u1_busy;

  int unsigned total;
  int unsigned bad;

  mms_stream_ctrl #(.DW(8), .N(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sel(out_sel), .busy(busy)
  );

  mms_stream_ctrl #(.DW(8), .N(1)) dut1 (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_data(u1_in_data),
    .in_sel(u1_in_sel), .out_valid(u1_out_valid), .out_ready(u1_out_ready),
    .out_result(u1_out_result), .out_sel(u1_out_sel), .busy(u1_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    cyc();
  endtask

  logic [7:0] v1 [8] = '{8'h20, 8'h05, 8'hFF, 8'h10, 8'h05, 8'h80, 8'h33, 8'h07};
  logic [7:0] gaps;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    out_ready = 1'b1;
    u1_in_valid = 1'b0;
    u1_in_data  = '0;
    u1_in_sel   = 1'b0;
    u1_out_ready = 1'b1;
    gaps = 8'b1011_0010;

    // Reset state
    cyc();
    cyc();
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready_after", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 8'h00);

    // 1: min of v1, back-to-back
    for (int i = 0; i < 8; i++) begin
      push(v1[i], 1'b1);
      if (i == 6) check("t1_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 8'h05);
    check("t1_sel", out_sel, 1);
    cyc();
    check("t1_valid_1cyc", out_valid, 0);
    check("t1_idle", busy, 0);

    // 2: max, in_sel toggled after the first sample
    for (int i = 0; i < 8; i++) push(v1[i], (i % 2) == 1);
    in_valid = 1'b0;
    check("t2_result", out_result, 8'hFF);
    check("t2_sel", out_sel, 0);
    cyc();

    // 3: back-pressure in DONE, then same-cycle handoff
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(v1[i], 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h42;
    in_sel   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_ready", in_ready, 0);
      cyc();
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_result", out_result, 8'h05);
    end
    out_ready = 1'b1;
    #1;
    check("t3_ready_up", in_ready, 1);
    cyc();
    check("t3_taken", out_valid, 0);
    check("t3_busy", busy, 1);
    for (int i = 1; i < 8; i++) push(8'(i), 1'b1);
    in_valid = 1'b0;
    check("t3_result", out_result, 8'h42);
    check("t3_sel", out_sel, 0);
    cyc();

    // 4: in_valid gaps stretch the frame
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        cyc();
        check("t4_gap_valid", out_valid, 0);
      end
      push(8'hAA, 1'b1);
    end
    in_valid = 1'b0;
    check("t4_valid", out_valid, 1);
    check("t4_result", out_result, 8'hAA);
    cyc();
    for (int i = 0; i < 8; i++) push(8'(i), 1'b0);
    in_valid = 1'b0;
    check("t4_ramp_result", out_result, 8'h07);
    cyc();

    // 5: clear mid-frame discards the partial result
    push(8'h01, 1'b1);
    push(8'h10, 1'b1);
    push(8'h20, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    #1;
    check("t5_clear_ready", in_ready, 0);
    cyc();
    clear = 1'b0;
    check("t5_clear_busy", busy, 0);
    check("t5_clear_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      push(8'hFF, 1'b1);
      if (i < 7) check("t5_no_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("t5_result", out_result, 8'hFF);
    cyc();

    // 6: reset mid-ACC and mid-DONE
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t6a_rst_ready", in_ready, 0);
    cyc();
    check("t6a_valid", out_valid, 0);
    check("t6a_result", out_result, 8'h00);
    check("t6a_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("t6a_ready_after", in_ready, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(v1[i], 1'b1);
    in_valid = 1'b0;
    check("t6b_in_done", out_valid, 1);
    reset = 1'b1;
    #1;
    check("t6b_rst_ready", in_ready, 0);
    cyc();
    check("t6b_valid", out_valid, 0);
    check("t6b_result", out_result, 8'h00);
    check("t6b_sel", out_sel, 0);
    check("t6b_busy", busy, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t6b_ready_after", in_ready, 1);
    for (int i = 0; i < 8; i++) push(8'h33, 1'b0);
    in_valid = 1'b0;
    check("t6b_fresh_result", out_result, 8'h33);
    cyc();

    // N=1 build: every sample is a frame, back-to-back
    u1_in_valid = 1'b1;
    u1_in_data  = 8'h5A;
    u1_in_sel   = 1'b1;
    cyc();
    check("n1_valid_a", u1_out_valid, 1);
    check("n1_result_a", u1_out_result, 8'h5A);
    check("n1_sel_a", u1_out_sel, 1);
    u1_in_data = 8'h3C;
    u1_in_sel  = 1'b0;
    cyc();
    check("n1_valid_b", u1_out_valid, 1);
    check("n1_result_b", u1_out_result, 8'h3C);
    check("n1_sel_b", u1_out_sel, 0);
    u1_in_valid = 1'b0;
    cyc();
    check("n1_idle", u1_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
